// File: rtl/if_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_unit
// Purpose  : Instruction-fetch unit. Holds the program counter, issues one
//            word fetch at a time to instruction memory, latches the returned
//            instruction into IR, and raises a sticky fault if memory does
//            not acknowledge within TIMEOUT cycles.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            npc, pc_wr        - next-PC word address and load request
//            fetch_start       - start a fetch at the current PC
//            imem_ack/rdata    - memory read-data strobe and data
//            pc                - current PC (word address)
//            imem_req/addr     - fetch request (held until ack) and address
//            ir, ir_valid      - instruction register and its valid flag
//            busy              - high while a fetch is outstanding
//            fault             - sticky fetch-timeout indicator
// Revision : 1.0 - initial release
// ============================================================================
module if_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] npc,
    input  logic        pc_wr,
    input  logic        fetch_start,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:2] pc,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [29:0] c_reset_word   = RESET_PC[31:2];
    localparam logic [7:0]  c_timeout_last = 8'(TIMEOUT - 1);

    state_t      r_state,    w_state;
    logic [29:0] r_pc,       w_pc;
    logic        r_req,      w_req;
    logic [29:0] r_addr,     w_addr;
    logic [31:0] r_ir,       w_ir;
    logic        r_ir_valid, w_ir_valid;
    logic        r_fault,    w_fault;
    logic [7:0]  r_cnt,      w_cnt;
    logic        r_pend,     w_pend;
    logic [29:0] r_pend_pc,  w_pend_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= c_reset_word;
            r_req      <= 1'b0;
            r_addr     <= c_reset_word;
            r_ir       <= 32'h0;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= 8'h0;
            r_pend     <= 1'b0;
            r_pend_pc  <= c_reset_word;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_req      <= w_req;
            r_addr     <= w_addr;
            r_ir       <= w_ir;
            r_ir_valid <= w_ir_valid;
            r_fault    <= w_fault;
            r_cnt      <= w_cnt;
            r_pend     <= w_pend;
            r_pend_pc  <= w_pend_pc;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_req      = r_req;
        w_addr     = r_addr;
        w_ir       = r_ir;
        w_ir_valid = r_ir_valid;
        w_fault    = r_fault;
        w_cnt      = r_cnt;
        w_pend     = r_pend;
        w_pend_pc  = r_pend_pc;

        case (r_state)
            IDLE: begin
                // A simultaneous fetch uses the old PC: w_addr takes r_pc.
                if (pc_wr) begin
                    w_pc = npc;
                end
                if (fetch_start) begin
                    w_state    = WAIT_ACK;
                    w_req      = 1'b1;
                    w_addr     = r_pc;
                    w_ir_valid = 1'b0;
                    w_cnt      = 8'h0;
                end
            end

            WAIT_ACK: begin
                if (imem_ack) begin
                    // Ack wins even on the final allowed cycle.
                    w_state    = IDLE;
                    w_ir       = imem_rdata;
                    w_ir_valid = 1'b1;
                    w_req      = 1'b0;
                end else if (r_cnt == c_timeout_last) begin
                    w_state = ERROR;
                    w_fault = 1'b1;
                    w_req   = 1'b0;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end

                // PC must not move while the address is on the bus, so writes
                // are parked and applied on the exit edge; a write on the
                // exit edge itself is newer than anything parked.
                if (imem_ack || (r_cnt == c_timeout_last)) begin
                    if (pc_wr) begin
                        w_pc = npc;
                    end else if (r_pend) begin
                        w_pc = r_pend_pc;
                    end
                    w_pend = 1'b0;
                end else if (pc_wr) begin
                    w_pend_pc = npc;
                    w_pend    = 1'b1;
                end
            end

            ERROR: begin
                // Terminal until reset; everything holds.
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign pc        = r_pc;
    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign fault     = r_fault;
    assign busy      = (r_state == WAIT_ACK);

endmodule
`default_nettype wire

// File: tb/tb_if_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_unit
// Purpose  : Self-checking bench for if_unit (TIMEOUT=4). A cycle-by-cycle
//            vector table covers fetch, simultaneous PC write, deferred PC
//            writes and ack on the last allowed cycle; hand-written sequences
//            cover timeout/ERROR and reset in the middle of a fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_unit;

    logic        clk;
    logic        rst;
    logic [31:2] npc;
    logic        pc_wr;
    logic        fetch_start;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:2] pc;
    logic        imem_req;
    logic [31:2] imem_addr;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fault;

    int errors = 0;
    int checks = 0;

    if_unit #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .pc_wr       (pc_wr),
        .fetch_start (fetch_start),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fs;
        logic        pcw;
        logic [29:0] npc;
        logic        ack;
        logic [31:0] rdata;
        logic [29:0] e_pc;
        logic        e_req;
        logic [29:0] e_addr;
        logic [31:0] e_ir;
        logic        e_iv;
        logic        e_busy;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic fs, input logic pcw,
                        input logic [29:0] n, input logic ack, input logic [31:0] rd);
        @(negedge clk);
        rst         = r;
        fetch_start = fs;
        pc_wr       = pcw;
        npc         = n;
        imem_ack    = ack;
        imem_rdata  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [29:0] e_pc, input logic e_req,
                             input logic [29:0] e_addr, input logic [31:0] e_ir,
                             input logic e_iv, input logic e_busy, input logic e_fault);
        chk({tag, ".pc"},       {2'b00, pc},        {2'b00, e_pc});
        chk({tag, ".imem_req"}, {31'h0, imem_req},  {31'h0, e_req});
        chk({tag, ".imem_addr"},{2'b00, imem_addr}, {2'b00, e_addr});
        chk({tag, ".ir"},       ir,                 e_ir);
        chk({tag, ".ir_valid"}, {31'h0, ir_valid},  {31'h0, e_iv});
        chk({tag, ".busy"},     {31'h0, busy},      {31'h0, e_busy});
        chk({tag, ".fault"},    {31'h0, fault},     {31'h0, e_fault});
    endtask

    initial begin
        rst = 1'b0; fetch_start = 1'b0; pc_wr = 1'b0; npc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        //                rst fs pcw npc         ack rdata          e_pc        req e_addr      e_ir           iv bsy flt
        // Reset then fetch, ack on 3rd wait cycle
        vecs.push_back('{1'b1,1'b0,1'b0,30'h0000,1'b0,32'h0,        30'h0C00,1'b0,30'h0C00,32'h0,         1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,30'h0000,1'b0,32'h0,        30'h0C00,1'b1,30'h0C00,32'h0,         1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b0,32'h0,        30'h0C00,1'b1,30'h0C00,32'h0,         1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b0,32'h0,        30'h0C00,1'b1,30'h0C00,32'h0,         1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b1,32'h2408_0005,30'h0C00,1'b0,30'h0C00,32'h2408_0005,1'b1,1'b0,1'b0});
        // Simultaneous fetch and PC write in IDLE: fetch uses old PC
        vecs.push_back('{1'b0,1'b1,1'b1,30'h0C01,1'b0,32'h0,        30'h0C01,1'b1,30'h0C00,32'h2408_0005,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b1,32'h0000_1111,30'h0C01,1'b0,30'h0C00,32'h0000_1111,1'b1,1'b0,1'b0});
        // PC write in IDLE back to 0xC00
        vecs.push_back('{1'b0,1'b0,1'b1,30'h0C00,1'b0,32'h0,        30'h0C00,1'b0,30'h0C00,32'h0000_1111,1'b1,1'b0,1'b0});
        // Deferred PC writes: last one wins on ack edge
        vecs.push_back('{1'b0,1'b1,1'b0,30'h0000,1'b0,32'h0,        30'h0C00,1'b1,30'h0C00,32'h0000_1111,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,30'h0D00,1'b0,32'h0,        30'h0C00,1'b1,30'h0C00,32'h0000_1111,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,30'h0D04,1'b0,32'h0,        30'h0C00,1'b1,30'h0C00,32'h0000_1111,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b1,32'hAAAA_5555,30'h0D04,1'b0,30'h0C00,32'hAAAA_5555,1'b1,1'b0,1'b0});
        // PC write on the exit edge beats the pending value
        vecs.push_back('{1'b0,1'b1,1'b0,30'h0000,1'b0,32'h0,        30'h0D04,1'b1,30'h0D04,32'hAAAA_5555,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,30'h0E00,1'b0,32'h0,        30'h0D04,1'b1,30'h0D04,32'hAAAA_5555,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,30'h0E10,1'b1,32'h1234_5678,30'h0E10,1'b0,30'h0D04,32'h1234_5678,1'b1,1'b0,1'b0});
        // Ack on the 4th (last allowed) wait cycle: no fault
        vecs.push_back('{1'b0,1'b1,1'b0,30'h0000,1'b0,32'h0,        30'h0E10,1'b1,30'h0E10,32'h1234_5678,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b0,32'h0,        30'h0E10,1'b1,30'h0E10,32'h1234_5678,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b0,32'h0,        30'h0E10,1'b1,30'h0E10,32'h1234_5678,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b0,32'h0,        30'h0E10,1'b1,30'h0E10,32'h1234_5678,1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b1,32'hDEAD_BEEF,30'h0E10,1'b0,30'h0E10,32'hDEAD_BEEF,1'b1,1'b0,1'b0});
        // Ack outside WAIT_ACK is ignored
        vecs.push_back('{1'b0,1'b0,1'b0,30'h0000,1'b1,32'hFFFF_FFFF,30'h0E10,1'b0,30'h0E10,32'hDEAD_BEEF,1'b1,1'b0,1'b0});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].fs, vecs[i].pcw, vecs[i].npc, vecs[i].ack, vecs[i].rdata);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req, vecs[i].e_addr,
                      vecs[i].e_ir, vecs[i].e_iv, vecs[i].e_busy, vecs[i].e_fault);
        end

        // Timeout: fetch at 0xE10, no ack; parked PC write applied on the fault edge
        step(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 32'h0);
        check_all("to_start", 30'h0E10, 1'b1, 30'h0E10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 30'h0F00, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 32'h0);
        check_all("to_wait3", 30'h0E10, 1'b1, 30'h0E10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 32'h0);
        check_all("to_fault", 30'h0F00, 1'b0, 30'h0E10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        // ERROR ignores fetch_start, pc_wr and ack
        step(1'b0, 1'b1, 1'b1, 30'h0123, 1'b1, 32'h5A5A_5A5A);
        check_all("err_hold1", 30'h0F00, 1'b0, 30'h0E10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 32'h5A5A_5A5A);
        check_all("err_hold2", 30'h0F00, 1'b0, 30'h0E10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 32'h0);
        check_all("err_rst", 30'h0C00, 1'b0, 30'h0C00, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a fetch; a late ack is ignored
        step(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 32'h0);
        check_all("mid_start", 30'h0C00, 1'b1, 30'h0C00, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 30'h0D00, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 32'h0);
        check_all("mid_rst", 30'h0C00, 1'b0, 30'h0C00, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 32'h5555_5555);
        check_all("late_ack", 30'h0C00, 1'b0, 30'h0C00, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
